// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - uart_state_e : frame FSM state encoding
//   - DATA_W       : payload width of one character
//   - PAR_EVEN/ODD : parity-mode selectors
//   - calc_div     : sys_clk cycles per line bit
//   - calc_parity  : parity bit for one character
package uart_pkg;

   localparam int DATA_W = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Integer floor: the fractional part shows up as a small baud-rate error.
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Even mode gives XOR of the data, so data plus parity has an even count of ones.
   // Odd mode inverts that.
   function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic mode);
      return (^data) ^ mode;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake into the UART transmitter.
//   tx_data  : byte to transmit (master -> slave)
//   tx_valid : tx_data is valid this cycle (master -> slave)
//   tx_ready : transmitter can take a byte this cycle (slave -> master)
// A byte is transferred on any sys_clk edge where tx_valid && tx_ready.
interface uart_tx_if;

   logic [uart_pkg::DATA_W-1:0] tx_data;
   logic                        tx_valid;
   logic                        tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART.
//   sys_clk : system clock
//   rst     : asynchronous reset, active-high
//   en      : count while high; the counter is held at 0 while low
//   clr     : synchronous clear to 0
//   tick    : high on the last cycle of each bit period (count == DIV-1)
module uart_baud_tick #(
   parameter int DIV = 434
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;

   // Bit-period counter: 0..DIV-1, wraps on the tick, parked at 0 when disabled.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr || !en) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // The tick decodes a register and not external inputs, so it is glitch-free within the clock domain.
   assign tick = en && (cnt_r == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
//   sys_clk    : system clock, all logic on the rising edge
//   rst        : asynchronous reset, active-high
//   tx_if      : byte handshake (tx_data / tx_valid / tx_ready), slave side
//   serial_out : UART line, idle high
//   busy       : a frame is in progress
// Frame format: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits.
// Each bit lasts DIV = CLK_FREQ/BAUD cycles.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic     sys_clk,
   input  logic     rst,
   uart_tx_if.slave tx_if,
   output logic     serial_out,
   output logic     busy
);

   localparam int         DIV       = calc_div(CLK_FREQ, BAUD);
   localparam logic       PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   generate
      if (DIV < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
         $error("uart_tx: illegal parameters (CLK_FREQ/BAUD must be >= 2, STOP_BITS must be 1 or 2)");
      end
   endgenerate

   uart_state_e        state_r, next_state_s;
   logic [DATA_W-1:0]  shift_r, shift_next_s;
   logic [2:0]         bit_cnt_r, bit_cnt_next_s;
   logic               parity_r, parity_next_s;
   logic               serial_r, serial_next_s;
   logic               ready_r, busy_r;
   logic               tick_s, accept_s;

   // ready_r is a registered copy of (state_r == ST_IDLE), so it qualifies the handshake directly.
   assign accept_s = tx_if.tx_valid && ready_r;

   uart_baud_tick #(.DIV(DIV)) u_baud_tick (
      .sys_clk (sys_clk),
      .rst     (rst),
      .en      (state_r != ST_IDLE),
      .clr     (accept_s),
      .tick    (tick_s)
   );

   // Next-state, shifter and bit-counter logic. Every step is gated by the baud tick.
   always_comb begin
      next_state_s   = state_r;
      shift_next_s   = shift_r;
      bit_cnt_next_s = bit_cnt_r;
      parity_next_s  = parity_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s   = ST_START;
               shift_next_s   = tx_if.tx_data;
               parity_next_s  = calc_parity(tx_if.tx_data, PAR_MODE);
               bit_cnt_next_s = 3'd0;
            end else begin
               next_state_s   = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               next_state_s   = ST_DATA;
               bit_cnt_next_s = 3'd0;
            end else begin
               next_state_s   = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_next_s = {1'b0, shift_r[DATA_W-1:1]};
               if (bit_cnt_r == 3'd7) begin
                  next_state_s   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  bit_cnt_next_s = 3'd0;
               end else begin
                  bit_cnt_next_s = bit_cnt_r + 3'd1;
               end
            end else begin
               next_state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (tick_s) begin
               next_state_s   = ST_STOP;
               bit_cnt_next_s = 3'd0;
            end else begin
               next_state_s   = ST_PARITY;
            end
         end
         ST_STOP: begin
            // In this state the bit counter counts stop bits.
            if (tick_s) begin
               if (bit_cnt_r == STOP_LAST) begin
                  next_state_s   = ST_IDLE;
                  bit_cnt_next_s = 3'd0;
               end else begin
                  bit_cnt_next_s = bit_cnt_r + 3'd1;
               end
            end else begin
               next_state_s = ST_STOP;
            end
         end
         default: begin
            next_state_s   = ST_IDLE;
            bit_cnt_next_s = 3'd0;
         end
      endcase
   end

   // Line level for the next cycle. It is taken from the next state so that serial_out can be a flop with no added latency.
   always_comb begin
      serial_next_s = 1'b1;
      case (next_state_s)
         ST_IDLE:   serial_next_s = 1'b1;
         ST_START:  serial_next_s = 1'b0;
         ST_DATA:   serial_next_s = shift_next_s[0];
         ST_PARITY: serial_next_s = parity_next_s;
         ST_STOP:   serial_next_s = 1'b1;
         default:   serial_next_s = 1'b1;
      endcase
   end

   // State and output registers. Reset forces the line idle-high at once and abandons any partial frame.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         shift_r   <= '0;
         bit_cnt_r <= 3'd0;
         parity_r  <= 1'b0;
         serial_r  <= 1'b1;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         shift_r   <= shift_next_s;
         bit_cnt_r <= bit_cnt_next_s;
         parity_r  <= parity_next_s;
         serial_r  <= serial_next_s;
         ready_r   <= (next_state_s == ST_IDLE);
         busy_r    <= (next_state_s != ST_IDLE);
      end
   end

   assign tx_if.tx_ready = ready_r;
   assign serial_out     = serial_r;
   assign busy           = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Four transmitters share one clock and reset. All run at DIV = 8 and differ in framing:
//   0: even parity, 1 stop   1: odd parity, 1 stop   2: no parity, 1 stop   3: even parity, 2 stops
// Each line is recorded cycle by cycle into queues.
// The recording is compared against a frame model built from the framing rules.
module tb_uart_tx;

   localparam int DIV = 8;
   localparam int PAR_EN_C [4] = '{1, 1, 0, 1};
   localparam int ODD_C    [4] = '{0, 1, 0, 0};
   localparam int STOPS_C  [4] = '{1, 1, 1, 2};

   logic       sys_clk = 1'b0;
   logic       rst;
   logic [7:0] tdata [4];
   logic [3:0] tvalid;
   wire  [3:0] ser_s, bsy_s, rdy_s;

   int n_checks = 0;
   int n_fail   = 0;

   logic line_q[$], busy_q[$], rdy_q[$];

   always #5 sys_clk = ~sys_clk;

   uart_tx_if if_a (), if_b (), if_c (), if_d ();

   assign if_a.tx_data = tdata[0];  assign if_a.tx_valid = tvalid[0];  assign rdy_s[0] = if_a.tx_ready;
   assign if_b.tx_data = tdata[1];  assign if_b.tx_valid = tvalid[1];  assign rdy_s[1] = if_b.tx_ready;
   assign if_c.tx_data = tdata[2];  assign if_c.tx_valid = tvalid[2];  assign rdy_s[2] = if_c.tx_ready;
   assign if_d.tx_data = tdata[3];  assign if_d.tx_valid = tvalid[3];  assign rdy_s[3] = if_d.tx_ready;

   uart_tx #(.CLK_FREQ(8), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
      .sys_clk(sys_clk), .rst(rst), .tx_if(if_a), .serial_out(ser_s[0]), .busy(bsy_s[0]));
   uart_tx #(.CLK_FREQ(8), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_b (
      .sys_clk(sys_clk), .rst(rst), .tx_if(if_b), .serial_out(ser_s[1]), .busy(bsy_s[1]));
   uart_tx #(.CLK_FREQ(8), .BAUD(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_c (
      .sys_clk(sys_clk), .rst(rst), .tx_if(if_c), .serial_out(ser_s[2]), .busy(bsy_s[2]));
   uart_tx #(.CLK_FREQ(8), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_d (
      .sys_clk(sys_clk), .rst(rst), .tx_if(if_d), .serial_out(ser_s[3]), .busy(bsy_s[3]));

   // Frame model: the k-th line bit of a frame carrying byte d.
   function automatic logic exp_bit(input int idx, input logic [7:0] d, input int k);
      int ones;
      ones = $countones(d);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (PAR_EN_C[idx] != 0 && k == 9) return ((ones + ODD_C[idx]) % 2) == 1;
      return 1'b1;
   endfunction

   function automatic int frame_len(input int idx);
      return (1 + 8 + PAR_EN_C[idx] + STOPS_C[idx]) * DIV;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Record n cycles of one transmitter, sampled on the falling edge.
   task automatic capture(input int idx, input int n);
      repeat (n) begin
         @(negedge sys_clk);
         line_q.push_back(ser_s[idx]);
         busy_q.push_back(bsy_s[idx]);
         rdy_q.push_back(rdy_s[idx]);
      end
   endtask

   task automatic clear_q();
      line_q.delete();
      busy_q.delete();
      rdy_q.delete();
   endtask

   // Present byte d, returning just after the accepting edge. The first recorded sample after this is the first START cycle.
   task automatic start_tx(input int idx, input logic [7:0] d, input bit hold);
      @(negedge sys_clk);
      chk($sformatf("ready_before_tx%0d", idx), rdy_s[idx], 1);
      tdata[idx]  = d;
      tvalid[idx] = 1'b1;
      @(posedge sys_clk);
      #1;
      if (!hold) tvalid[idx] = 1'b0;
   endtask

   // Check a recorded frame for byte d that starts at sample s.
   task automatic check_frame(input string tag, input int idx, input int s, input logic [7:0] d);
      int nb, flen, nbusy, nrdy;
      logic [7:0] dec;
      flen = frame_len(idx);
      nb   = flen / DIV;
      for (int k = 0; k < nb; k++) begin
         chk($sformatf("%s bit%0d first", tag, k), line_q[s + k*DIV], exp_bit(idx, d, k));
         chk($sformatf("%s bit%0d centre", tag, k), line_q[s + k*DIV + DIV/2], exp_bit(idx, d, k));
         chk($sformatf("%s bit%0d last", tag, k), line_q[s + k*DIV + DIV-1], exp_bit(idx, d, k));
      end
      nbusy = 0;
      nrdy  = 0;
      for (int i = s; i < s + flen; i++) begin
         nbusy += busy_q[i] ? 1 : 0;
         nrdy  += rdy_q[i] ? 1 : 0;
      end
      chk({tag, " busy_cycles"}, nbusy, flen);
      chk({tag, " ready_cycles"}, nrdy, 0);
      chk({tag, " busy_after"}, busy_q[s + flen], 0);
      chk({tag, " ready_after"}, rdy_q[s + flen], 1);
      chk({tag, " line_after"}, line_q[s + flen], 1);
      for (int j = 0; j < 8; j++) dec[j] = line_q[s + (1 + j)*DIV + DIV/2];
      chk({tag, " decoded"}, dec, d);
   endtask

   initial begin
      int         fa, idx, zeros;
      logic [7:0] d;
      tvalid = 4'b0000;
      for (int i = 0; i < 4; i++) tdata[i] = 8'h00;
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("reset serial_out", ser_s, 4'hF);
      chk("reset busy", bsy_s, 4'h0);
      chk("reset tx_ready", rdy_s, 4'hF);
      rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      fa = frame_len(0);

      // Default frame: A5, even parity, one stop bit.
      clear_q();
      start_tx(0, 8'hA5, 1'b0);
      capture(0, fa + 3);
      check_frame("a5_even", 0, 0, 8'hA5);

      // Odd parity, all-zero byte: the parity bit must be 1.
      clear_q();
      start_tx(1, 8'h00, 1'b0);
      capture(1, frame_len(1) + 3);
      check_frame("00_odd", 1, 0, 8'h00);
      chk("00_odd parity_slot", line_q[9*DIV + DIV/2], 1);

      // No parity: 80-cycle frame.
      clear_q();
      start_tx(2, 8'hFF, 1'b0);
      capture(2, frame_len(2) + 3);
      check_frame("ff_nopar", 2, 0, 8'hFF);

      // Two stop bits: 16 high cycles after parity.
      clear_q();
      start_tx(3, 8'h81, 1'b0);
      capture(3, frame_len(3) + 3);
      check_frame("81_stop2", 3, 0, 8'h81);

      // Back-to-back with tx_valid held. tx_data changes right after the first accept.
      clear_q();
      start_tx(0, 8'h55, 1'b1);
      tdata[0] = 8'h0F;
      capture(0, 2*fa + 2);
      tvalid[0] = 1'b0;
      check_frame("b2b_first", 0, 0, 8'h55);
      chk("b2b idle_gap", line_q[fa], 1);
      chk("b2b second_start", line_q[fa + 1], 0);
      check_frame("b2b_second", 0, fa + 1, 8'h0F);
      capture(0, 4);

      // Request during a frame is ignored.
      clear_q();
      start_tx(0, 8'h3C, 1'b0);
      capture(0, 30);
      tdata[0]  = 8'h33;
      tvalid[0] = 1'b1;
      capture(0, 1);
      tvalid[0] = 1'b0;
      capture(0, fa + 20 - 31);
      check_frame("ignored", 0, 0, 8'h3C);
      zeros = 0;
      for (int i = fa; i < fa + 20; i++) zeros += line_q[i] ? 0 : 1;
      chk("ignored no_extra_frame", zeros, 0);

      // Reset during data bit 3. The outputs must respond without a clock edge.
      clear_q();
      d = 8'($urandom);
      start_tx(0, d, 1'b0);
      capture(0, 4*DIV + 3);
      chk("midreset busy_before", busy_q[4*DIV + 2], 1);
      #1 rst = 1'b1;
      #1;
      chk("midreset serial_out", ser_s[0], 1);
      chk("midreset busy", bsy_s[0], 0);
      chk("midreset tx_ready", rdy_s[0], 1);
      @(negedge sys_clk);
      rst = 1'b0;
      clear_q();
      d = 8'($urandom);
      start_tx(0, d, 1'b0);
      capture(0, fa + 3);
      check_frame("after_reset", 0, 0, d);

      // Random bytes on random framings.
      for (int t = 0; t < 6; t++) begin
         idx = $urandom_range(0, 3);
         d   = 8'($urandom);
         clear_q();
         start_tx(idx, d, 1'b0);
         capture(idx, frame_len(idx) + 3);
         check_frame($sformatf("rand%0d_tx%0d", t, idx), idx, 0, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
